// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and helpers for the radix-4 Booth multiplier.
//                - state_e    : control FSM states (IDLE, CALC, DONE)
//                - pp_sel_e   : partial-product selection from Booth recoding
//                - iter_count : number of radix-4 steps for an N-bit operand
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_P1   = 3'd1,
        PP_P2   = 3'd2,
        PP_M1   = 3'd3,
        PP_M2   = 3'd4
    } pp_sel_e;

    // Operands are extended to N+2 bits; each radix-4 step retires two
    // multiplier bits, so (N+2)/2 steps cover every significant bit.
    function automatic int iter_count(input int n);
        return (n + 2) / 2;
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_r4_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_recoder
//  Description : Combinational radix-4 Booth recoder. Maps the multiplier
//                triplet {b(2i+1), b(2i), b(2i-1)} to a partial-product
//                selection in {0, +M, +2M, -M, -2M}.
//  Ports       : triplet (in, 3)  multiplier bit triplet
//                pp_sel  (out)    partial-product selection
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output pp_sel_e    pp_sel
);

    always_comb begin
        pp_sel = PP_ZERO;
        case (triplet)
            3'b000, 3'b111: pp_sel = PP_ZERO;
            3'b001, 3'b010: pp_sel = PP_P1;
            3'b011:         pp_sel = PP_P2;
            3'b100:         pp_sel = PP_M2;
            3'b101, 3'b110: pp_sel = PP_M1;
            default:        pp_sel = PP_ZERO;
        endcase
    end

endmodule : booth_r4_recoder
`default_nettype wire

// File: rtl/booth_r4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_mult
//  Description : Sequential radix-4 Booth multiplier, N-bit operands,
//                per-operation signed/unsigned mode, ready/valid input,
//                fixed latency of ITER cycles from acceptance to done.
//  Ports       : clk, rst (sync, active high)
//                valid, signed_mode, multiplicando[N], multiplicador[N] (in)
//                ready, resultado[2N], done (out)
//                resultado_sat[N], ovf (out, only with BOOTH_SAT_EN)
//  Options     : `define BOOTH_SAT_EN adds the saturated N-bit result and
//                its overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             signed_mode,
    input  logic [N-1:0]     multiplicando,
    input  logic [N-1:0]     multiplicador,
    output logic             ready,
    output logic [2*N-1:0]   resultado,
    output logic             done
`ifdef BOOTH_SAT_EN
    ,
    output logic [N-1:0]     resultado_sat,
    output logic             ovf
`endif
);

    localparam int ITER = iter_count(N);
    localparam int XW   = N + 2;          // extended operand width
    localparam int AW   = XW + 1;         // upper accumulator half (holds +-2M)
    localparam int ACCW = AW + XW;        // full accumulator: 2(N+2)+1
    localparam int OFF  = XW - 2 * ITER;  // leftover multiplier bit for odd N
    localparam int CW   = $clog2(ITER + 1);

    state_e              state_q, state_d;
    logic [XW-1:0]       mcand_q, mcand_d;
    logic [ACCW-1:0]     acc_q, acc_d;
    logic                bm1_q, bm1_d;     // b(-1) / previous multiplier bit
    logic [CW-1:0]       count_q, count_d;
    logic [2*N-1:0]      resultado_q, resultado_d;
    logic                done_q, done_d;

    logic [2:0]          triplet;
    pp_sel_e             pp_sel;
    logic [AW-1:0]       m1, m2, pp, a_sum;
    logic [ACCW-1:0]     acc_step;
    logic [2*N-1:0]      product;
    logic [XW-1:0]       mcand_ext, mplier_ext;

    assign triplet = {acc_q[1], acc_q[0], bm1_q};

    booth_r4_recoder u_recoder (
        .triplet (triplet),
        .pp_sel  (pp_sel)
    );

    always_comb begin
        m1 = {mcand_q[XW-1], mcand_q};
        m2 = {mcand_q, 1'b0};
        pp = '0;
        case (pp_sel)
            PP_ZERO: pp = '0;
            PP_P1:   pp = m1;
            PP_P2:   pp = m2;
            PP_M1:   pp = -m1;
            PP_M2:   pp = -m2;
            default: pp = '0;
        endcase
        a_sum    = acc_q[ACCW-1:XW] + pp;
        acc_step = ACCW'($signed({a_sum, acc_q[XW-1:0]}) >>> 2);
        // After ITER steps the product sits at the bottom of the accumulator,
        // above any multiplier bit not consumed when N is odd.
        product  = acc_step[2*N-1+OFF:OFF];
    end

    always_comb begin
        mcand_ext  = signed_mode ? {{2{multiplicando[N-1]}}, multiplicando}
                                 : {2'b00, multiplicando};
        mplier_ext = signed_mode ? {{2{multiplicador[N-1]}}, multiplicador}
                                 : {2'b00, multiplicador};
    end

`ifdef BOOTH_SAT_EN
    logic            mode_q, mode_d;
    logic [N-1:0]    sat_q, sat_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    sat_w;
    logic            ovf_w;

    always_comb begin
        if (mode_q) begin
            // Signed result fits N bits when bits [2N-1:N-1] are all equal.
            ovf_w = ~((&product[2*N-1:N-1]) | ~(|product[2*N-1:N-1]));
            if (!ovf_w)
                sat_w = product[N-1:0];
            else if (product[2*N-1])
                sat_w = {1'b1, {(N-1){1'b0}}};
            else
                sat_w = {1'b0, {(N-1){1'b1}}};
        end else begin
            ovf_w = |product[2*N-1:N];
            sat_w = ovf_w ? {N{1'b1}} : product[N-1:0];
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        bm1_d       = bm1_q;
        count_d     = count_q;
        resultado_d = resultado_q;
        done_d      = 1'b0;
        ready       = (state_q != CALC);
`ifdef BOOTH_SAT_EN
        mode_d      = mode_q;
        sat_d       = sat_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (valid) begin
                    mcand_d = mcand_ext;
                    acc_d   = {{AW{1'b0}}, mplier_ext};
                    bm1_d   = 1'b0;
                    count_d = '0;
`ifdef BOOTH_SAT_EN
                    mode_d  = signed_mode;
`endif
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d   = acc_step;
                bm1_d   = acc_q[1];
                count_d = count_q + CW'(1);
                if (count_q == CW'(ITER - 1)) begin
                    resultado_d = product;
                    done_d      = 1'b1;
`ifdef BOOTH_SAT_EN
                    sat_d       = sat_w;
                    ovf_d       = ovf_w;
`endif
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            bm1_q       <= 1'b0;
            count_q     <= '0;
            resultado_q <= '0;
            done_q      <= 1'b0;
`ifdef BOOTH_SAT_EN
            mode_q      <= 1'b0;
            sat_q       <= '0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            bm1_q       <= bm1_d;
            count_q     <= count_d;
            resultado_q <= resultado_d;
            done_q      <= done_d;
`ifdef BOOTH_SAT_EN
            mode_q      <= mode_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign resultado = resultado_q;
    assign done      = done_q;
`ifdef BOOTH_SAT_EN
    assign resultado_sat = sat_q;
    assign ovf           = ovf_q;
`endif

endmodule : booth_r4_mult
`default_nettype wire

// File: tb/tb_booth_r4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_r4_mult
//  Description : Self-checking bench for booth_r4_mult (N=8). Directed and
//                random operations compared against a plain-arithmetic
//                product model; handshake, latency and reset-abort checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_mult;

    localparam int N    = 8;
    localparam int ITER = (N + 2) / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid = 1'b0;
    logic           signed_mode = 1'b0;
    logic [N-1:0]   multiplicando = '0;
    logic [N-1:0]   multiplicador = '0;
    logic           ready;
    logic [2*N-1:0] resultado;
    logic           done;
`ifdef BOOTH_SAT_EN
    logic [N-1:0]   resultado_sat;
    logic           ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    booth_r4_mult #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .signed_mode   (signed_mode),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .ready         (ready),
        .resultado     (resultado),
        .done          (done)
`ifdef BOOTH_SAT_EN
        ,
        .resultado_sat (resultado_sat),
        .ovf           (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product: integer multiply of the operands as interpreted by mode.
    function automatic longint full_prod(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        longint pa, pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return pa * pb;
    endfunction

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [63:0] p;
        p = 64'(full_prod(a, b, s));
        return p[2*N-1:0];
    endfunction

    task automatic ref_sat(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           output logic [N-1:0] sat, output logic o);
        longint p, lo, hi, c;
        logic [63:0] cv;
        p  = full_prod(a, b, s);
        lo = s ? -(longint'(1) << (N - 1)) : 0;
        hi = s ? (longint'(1) << (N - 1)) - 1 : (longint'(1) << N) - 1;
        c  = (p > hi) ? hi : ((p < lo) ? lo : p);
        o  = (c != p);
        cv = 64'(c);
        sat = cv[N-1:0];
    endtask

    // One operation: present at an idle point, change inputs after acceptance,
    // then verify latency, pulse width and result.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic [N-1:0] a_busy, input logic [N-1:0] b_busy);
        int cyc;
        logic [N-1:0] es;
        logic eo;
        check("ready_before_op", 64'(ready), 64'd1);
        multiplicando = a;
        multiplicador = b;
        signed_mode   = s;
        valid         = 1'b1;
        @(posedge clk); #1;
        valid         = 1'b0;
        multiplicando = a_busy;
        multiplicador = b_busy;
        signed_mode   = ~s;
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * ITER) begin
            check("ready_low_in_calc", 64'(ready), 64'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("done_latency", 64'(cyc), 64'(ITER));
        check("resultado", 64'(resultado), 64'(ref_prod(a, b, s)));
`ifdef BOOTH_SAT_EN
        ref_sat(a, b, s, es, eo);
        check("resultado_sat", 64'(resultado_sat), 64'(es));
        check("ovf", 64'(ovf), 64'(eo));
`else
        es = '0;
        eo = 1'b0;
`endif
        check("ready_in_done", 64'(ready), 64'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("resultado_held", 64'(resultado), 64'(ref_prod(a, b, s)));
    endtask

    logic [N-1:0] exp_q_a[$];
    logic [N-1:0] exp_q_b[$];
    logic         exp_q_s[$];

    initial begin
        logic [N-1:0] ra, rb;
        logic         rs;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_resultado", 64'(resultado), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ready", 64'(ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed basics
        do_op(8'd10, 8'd10, 1'b1, 8'h5A, 8'hA5);
        do_op(8'd50, 8'(-2), 1'b1, 8'h01, 8'hFF);
        do_op(8'(-99), 8'd1, 1'b1, 8'h33, 8'h44);
        do_op(8'd99, 8'(-99), 1'b1, 8'h00, 8'h00);
        do_op(8'(-50), 8'(-50), 1'b1, 8'h7F, 8'h80);

        // Extremes and zeros
        do_op(8'h80, 8'h80, 1'b1, 8'd3, 8'd3);
        do_op(8'h80, 8'd127, 1'b1, 8'd3, 8'd3);
        do_op(8'd255, 8'd255, 1'b0, 8'd1, 8'd1);
        do_op(8'd128, 8'd2, 1'b0, 8'd9, 8'd9);
        do_op(8'd0, 8'h9C, 1'b1, 8'hFF, 8'hFF);
        do_op(8'hFF, 8'd0, 1'b0, 8'hFF, 8'hFF);

        // Operand change after acceptance
        do_op(8'd15, 8'(-15), 1'b1, 8'd7, 8'd7);

        // Saturation cases (also valid product checks without the option)
        do_op(8'd99, 8'd99, 1'b1, 8'd0, 8'd0);
        do_op(8'(-35), 8'd35, 1'b1, 8'd0, 8'd0);
        do_op(8'd5, 8'(-6), 1'b1, 8'd0, 8'd0);
        do_op(8'd16, 8'd16, 1'b0, 8'd0, 8'd0);

        // Random operations in both modes
        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, 8'($urandom), 8'($urandom));
        end

        // Continuous valid: accepts happen only every ITER+1 cycles
        for (int j = 0; j <= 4 * (ITER + 1); j++) begin
            check("hs_ready", 64'(ready), 64'((j % (ITER + 1)) == 0));
            check("hs_done", 64'(done), 64'((j > 0) && ((j % (ITER + 1)) == 0)));
            if (done === 1'b1 && exp_q_a.size() > 0) begin
                ra = exp_q_a.pop_front();
                rb = exp_q_b.pop_front();
                rs = exp_q_s.pop_front();
                check("hs_resultado", 64'(resultado), 64'(ref_prod(ra, rb, rs)));
            end
            multiplicando = 8'($urandom);
            multiplicador = 8'($urandom);
            signed_mode   = 1'($urandom_range(0, 1));
            if (j <= 3 * (ITER + 1))
                valid = 1'b1;
            else if (j < 4 * (ITER + 1))
                valid = 1'($urandom_range(0, 1));
            else
                valid = 1'b0;
            if (valid && (j % (ITER + 1)) == 0) begin
                exp_q_a.push_back(multiplicando);
                exp_q_b.push_back(multiplicador);
                exp_q_s.push_back(signed_mode);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("hs_queue_drained", 64'(exp_q_a.size()), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of an operation
        multiplicando = 8'd99;
        multiplicador = 8'd99;
        signed_mode   = 1'b1;
        valid         = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_resultado", 64'(resultado), 64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        for (int k = 0; k < 2 * ITER; k++) begin
            check("abort_no_done", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        do_op(8'd25, 8'd25, 1'b1, 8'd1, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_booth_r4_mult
`default_nettype wire
